// File: rtl/slow_vram_sched.sv
// slow_vram_sched: four-slot (fix, sprite even, sprite odd, CPU) scheduler for the slow VRAM; `SVRAM_HBLANK_CPU_EN lets the CPU steal sprite slots in HBLANK
module slow_vram_sched (
    input  logic        CLK_24M,
    input  logic        RESETP,
    input  logic        SYNC,
    input  logic        HBLANK,
    input  logic [14:0] FIXMAP_ADDR,
    input  logic [14:0] SPRMAP_ADDR,
    input  logic [14:0] CPU_ADDR,
    input  logic [15:0] CPU_WDATA,
    input  logic        CPU_WR,
    input  logic        CPU_REQ,
    output logic        CPU_ACK,
    output logic [15:0] CPU_RDATA,
    output logic [15:0] FIX_DATA,
    output logic        FIX_STB,
    output logic [15:0] SPR_DATA_EVEN,
    output logic [15:0] SPR_DATA_ODD,
    output logic        SPR_STB,
    output logic [14:0] SVRAM_ADDR,
    input  logic [15:0] SVRAM_DATA_IN,
    output logic [15:0] SVRAM_DATA_OUT,
    output logic        BOE,
    output logic        BWE,
    output logic [1:0]  SLOT
);
    logic [4:0]  phase, nphase;
    logic [2:0]  off, noff;
    logic [1:0]  nslot;
    logic        pend, act, n_act, n_cpu, req_q, wr_q, stole;
    logic        rise, take, steal_ok, cap;
    logic [14:0] addr_q;
    logic [15:0] wdata_q;
    logic        unused_sprmap_lsb;

    assign unused_sprmap_lsb = SPRMAP_ADDR[0];
    assign nphase = SYNC ? 5'd0 : phase + 5'd1;
    assign nslot  = nphase[4:3];
    assign noff   = nphase[2:0];
    assign off    = phase[2:0];
    assign SLOT   = phase[4:3];
    assign rise   = CPU_REQ && !req_q;
    assign take   = rise && (!pend || CPU_ACK);
`ifdef SVRAM_HBLANK_CPU_EN
    assign steal_ok = HBLANK && (nslot == 2'd1 || nslot == 2'd2);
`else
    logic unused_hblank;
    assign unused_hblank = HBLANK;
    assign steal_ok = 1'b0;
`endif
    // A CPU slot is decided at the edge that starts it; SYNC lands on slot 0 which never serves the CPU, aborting any transaction
    assign n_act = (noff == 3'd0) ? pend && (nslot == 2'd3 || steal_ok) : act;
    assign n_cpu = n_act || nslot == 2'd3;
    assign cap   = off == 3'd5 && !SYNC;

    // Phase counter, request capture and the pending/active transaction flags
    always_ff @(posedge CLK_24M) begin
        if (RESETP) begin
            phase   <= 5'd0;
            pend    <= 1'b0;
            act     <= 1'b0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            stole   <= 1'b0;
            addr_q  <= 15'd0;
            wdata_q <= 16'd0;
        end else begin
            phase <= nphase;
            req_q <= CPU_REQ;
            act   <= n_act;
            pend  <= take || (pend && !CPU_ACK);
            stole <= (nphase == 5'd0) ? 1'b0 : stole || (n_act && nslot != 2'd3);
            if (take) begin
                addr_q  <= CPU_ADDR;
                wdata_q <= CPU_WDATA;
                wr_q    <= CPU_WR;
            end
        end
    end

    // Registered SRAM pins, computed for the phase about to begin so they hold for the whole slot
    always_ff @(posedge CLK_24M) begin
        if (RESETP) begin
            SVRAM_ADDR     <= 15'd0;
            SVRAM_DATA_OUT <= 16'd0;
            BOE            <= 1'b1;
            BWE            <= 1'b1;
        end else begin
            SVRAM_ADDR <= n_cpu ? (n_act ? addr_q : 15'd0)
                        : (nslot == 2'd0) ? FIXMAP_ADDR : {SPRMAP_ADDR[14:1], nslot[1]};
            if (n_act && wr_q)
                SVRAM_DATA_OUT <= wdata_q;
            BOE <= SYNC || (n_cpu && !(n_act && !wr_q));
            BWE <= SYNC || !(n_act && wr_q && noff >= 3'd2 && noff <= 3'd5);
        end
    end

    // Read data capture at the end of offset 5, with strobes and ACK shown during offset 6
    always_ff @(posedge CLK_24M) begin
        if (RESETP) begin
            CPU_ACK       <= 1'b0;
            CPU_RDATA     <= 16'd0;
            FIX_DATA      <= 16'd0;
            FIX_STB       <= 1'b0;
            SPR_DATA_EVEN <= 16'd0;
            SPR_DATA_ODD  <= 16'd0;
            SPR_STB       <= 1'b0;
        end else begin
            CPU_ACK <= cap && act;
            FIX_STB <= cap && !act && SLOT == 2'd0;
            SPR_STB <= cap && !act && !stole && SLOT == 2'd2;
            if (cap && act && !wr_q)
                CPU_RDATA <= SVRAM_DATA_IN;
            if (cap && !act && SLOT == 2'd0)
                FIX_DATA <= SVRAM_DATA_IN;
            if (cap && !act && SLOT == 2'd1)
                SPR_DATA_EVEN <= SVRAM_DATA_IN;
            if (cap && !act && SLOT == 2'd2)
                SPR_DATA_ODD <= SVRAM_DATA_IN;
        end
    end
endmodule
